// File: rtl/load_diffusion_errors_pkg.sv
// rtl/load_diffusion_errors_pkg.sv - shared diffusion-error packing constants and FSM states
package load_diffusion_errors_pkg;

  // Packed chroma DC error word: four signed bytes, U0 U1 V0 V1 from the LSB up.
  localparam int DERR_W      = 32;
  localparam int DERR_ELEM_W = 8;

  // Byte-lane index of each element inside the packed word.
  localparam int DERR_LANE_U0 = 0;
  localparam int DERR_LANE_U1 = 1;
  localparam int DERR_LANE_V0 = 2;
  localparam int DERR_LANE_V1 = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_OUT
  } lde_state_t;

endpackage

// File: rtl/load_diffusion_errors_derr_fwd_snoop.sv
// rtl/load_diffusion_errors_derr_fwd_snoop.sv - snoops top-error RAM writes that race the context read
module derr_fwd_snoop
  import load_diffusion_errors_pkg::*;
#(
  parameter int XW = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              active,
  input  logic [XW-1:0]     match_addr,
  input  logic              wr_en,
  input  logic [XW-1:0]     wr_addr,
  input  logic [DERR_W-1:0] wr_data,
  output logic              hit,
  output logic [DERR_W-1:0] data
);

  logic              hit_q;
  logic [DERR_W-1:0] data_q;
  logic              hit_now;

  // A write landing on the capture edge itself must still win, so the live
  // match bypasses the held copy.
  always_comb begin
    hit_now = active && wr_en && (wr_addr == match_addr);
    hit     = hit_now || hit_q;
    data    = hit_now ? wr_data : data_q;
  end

  // Hold the most recent matching write for the duration of the load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_q  <= 1'b0;
      data_q <= '0;
    end else if (clear) begin
      hit_q  <= 1'b0;
    end else if (hit_now) begin
      hit_q  <= 1'b1;
      data_q <= wr_data;
    end
  end

endmodule

// File: rtl/load_diffusion_errors.sv
// rtl/load_diffusion_errors.sv - loads chroma DC top/left diffusion-error context (option LDE_WR_FORWARD_EN)
module load_diffusion_errors
  import load_diffusion_errors_pkg::*;
#(
  parameter int XW = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [XW-1:0]     x,
  input  logic [XW-1:0]     y,
  input  logic [DERR_W-1:0] left_derr_in,
  output logic              top_rd_en,
  output logic [XW-1:0]     top_rd_addr,
  input  logic [DERR_W-1:0] top_rd_data,
  input  logic              top_wr_en,
  input  logic [XW-1:0]     top_wr_addr,
  input  logic [DERR_W-1:0] top_wr_data,
  output logic [DERR_W-1:0] top_out,
  output logic [DERR_W-1:0] left_out,
  output logic              busy,
  output logic              done
);

  lde_state_t        state;
  logic [XW-1:0]     x_q;
  logic [XW-1:0]     y_q;
  logic [DERR_W-1:0] left_q;
  logic [DERR_W-1:0] fetched;
  logic              accept;

  assign accept = (state == S_IDLE) && start;

`ifdef LDE_WR_FORWARD_EN
  logic              fwd_hit;
  logic [DERR_W-1:0] fwd_data;
  logic              snoop_active;

  // Only writes seen after x is latched and up to the capture edge can be stale in the RAM read.
  assign snoop_active = (state == S_READ) || (state == S_WAIT);

  derr_fwd_snoop #(.XW(XW)) u_snoop (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (accept),
    .active     (snoop_active),
    .match_addr (x_q),
    .wr_en      (top_wr_en),
    .wr_addr    (top_wr_addr),
    .wr_data    (top_wr_data),
    .hit        (fwd_hit),
    .data       (fwd_data)
  );

  assign fetched = fwd_hit ? fwd_data : top_rd_data;
`else
  logic unused_snoop;
  assign unused_snoop = ^{top_wr_en, top_wr_addr, top_wr_data};
  assign fetched      = top_rd_data;
`endif

  // Fixed four-cycle load: issue the read unconditionally, capture, then pulse done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      left_q      <= '0;
      top_rd_en   <= 1'b0;
      top_rd_addr <= '0;
      top_out     <= '0;
      left_out    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            x_q         <= x;
            y_q         <= y;
            left_q      <= left_derr_in;
            top_rd_en   <= 1'b1;
            top_rd_addr <= x;
            busy        <= 1'b1;
            state       <= S_READ;
          end
        end
        S_READ: begin
          top_rd_en <= 1'b0;
          state     <= S_WAIT;
        end
        S_WAIT: begin
          top_out  <= (y_q == '0) ? '0 : fetched;
          left_out <= (x_q == '0) ? '0 : left_q;
          done     <= 1'b1;
          state    <= S_OUT;
        end
        S_OUT: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
